bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Digit-serial BCD adder/subtractor that processes DIGITS packed BCD digits one digit per clock, least significant digit first. Subtraction forms the 9's complement of each subtrahend digit on the fly, with the initial carry set to 1, so it computes the 10's complement. A negative difference is recomplemented in a second serial pass, giving a sign-magnitude result. It is the arithmetic consumer of per-digit 9's complement values and sits behind operand registers in the BCD datapath, with a start/done handshake to the controller.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥2)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = add (a+b), 1 = subtract (a−b); latched on start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]; latched on start
- b  in  4*DIGITS  operand B, packed BCD; latched on start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, result valid
- result  out  4*DIGITS  packed BCD sum or magnitude of difference
- carry_out  out  1  add: decimal overflow out of the top digit; sub: always 0
- sign  out  1  sub: 1 if a<b; add: always 0
- invalid  out  1  a latched digit was >9

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: on start=1, latch a, b, op. Check every digit. If any digit >9, go to DONE with invalid=1, result=0, carry_out=0, sign=0. Otherwise clear the digit index, set carry=op and go to PASS1.
- PASS1, one digit i per cycle: bd = op ? (9−b_i) : b_i; s = a_i + bd + carry (5-bit, 0..19). If s>9: digit=(s+6)[3:0], carry=1; else digit=s[3:0], carry=0. Write the digit to result slot i.
- After digit DIGITS−1:
  - add: carry_out=final carry → DONE.
  - sub with final carry=1 (a≥b): sign=0 → DONE.
  - sub with final carry=0 (a<b): sign=1, index=0, rc=1 → PASS2.
- PASS2, one digit per cycle: t = (9−r_i) + rc. If t=10: digit=0, rc=1; else digit=t, rc=0. This replaces result with its 10's complement, the magnitude. After the last digit → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- result, carry_out, sign and invalid are registered. They clear on accepted start and otherwise hold until the next accepted start.
- start is ignored while busy or in DONE. Operand changes after acceptance have no effect.
- All internal arithmetic is in 5 bits. Only valid BCD digits are ever written to result.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, carry_out=0, sign=0, invalid=0. Index and carry are cleared.
- Reset in any state aborts the operation on the next edge. No done pulse is produced for the aborted operation.
- Count cycles with start=1 in cycle 0 (accepted at the edge ending cycle 0).
- Add, or sub with a≥b: busy in cycles 1..DIGITS; done in cycle DIGITS+1.
- Sub with a<b: busy in cycles 1..2·DIGITS; done in cycle 2·DIGITS+1.
- Invalid operand: busy never rises; done and invalid are seen in cycle 1.
- The next start is accepted no earlier than the cycle after done.
- a=b for sub: result=0, sign=0, no PASS2.

## Test plan
- DIGITS=4, add a=0x1234 b=0x5678 -> done in cycle 5, result=0x6912, carry_out=0, sign=0.
- Add a=0x9999 b=0x0001 -> result=0x0000, carry_out=1; add 0x0000+0x0000 -> result=0x0000, carry_out=0.
- Sub a=0x5000 b=0x1234 -> done in cycle 5, result=0x3766, sign=0. Sub a=0x4321 b=0x4321 -> result=0x0000, sign=0.
- Sub a=0x1234 b=0x5000 -> PASS1 produces 0x6234, then done in cycle 9 with result=0x3766, sign=1, carry_out=0.
- Invalid: a=0x12A4 -> done in cycle 1, invalid=1, result=0. A following valid add 0x0001+0x0002 -> invalid=0, result=0x0003.
- Control: rst in cycle 3 of a sub -> IDLE, all outputs 0, no done pulse. start pulsed while busy -> ignored, first result unchanged. Back-to-back starts give correct results and one done pulse each.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction uses 10's complement; a negative result is recomplemented in a second pass.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_out,
    output logic                sign,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      r_dig;
    logic [4:0]      bd;
    logic [4:0]      s;
    logic [4:0]      t;
    logic [3:0]      sum_dig;
    logic            sum_c;
    logic [3:0]      comp_dig;
    logic            comp_c;
    logic            last;
    logic            start_bad;

    function automatic logic has_bad_digit(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // carry doubles as the recomplement carry (rc) during PASS2
    always_comb begin
        a_dig    = a_q[{idx, 2'b00} +: 4];
        b_dig    = b_q[{idx, 2'b00} +: 4];
        r_dig    = result[{idx, 2'b00} +: 4];
        bd       = op_q ? (5'd9 - {1'b0, b_dig}) : {1'b0, b_dig};
        s        = {1'b0, a_dig} + bd + {4'b0000, carry};
        sum_dig  = s[3:0];
        sum_c    = 1'b0;
        if (s > 5'd9) begin
            sum_dig = s[3:0] + 4'd6;
            sum_c   = 1'b1;
        end
        t        = 5'd9 - {1'b0, r_dig} + {4'b0000, carry};
        comp_dig = t[3:0];
        comp_c   = 1'b0;
        if (t == 5'd10) begin
            comp_dig = 4'd0;
            comp_c   = 1'b1;
        end
        last      = (idx == IW'(DIGITS - 1));
        start_bad = has_bad_digit(a) | has_bad_digit(b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            sign      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op;
                        result    <= '0;
                        carry_out <= 1'b0;
                        sign      <= 1'b0;
                        invalid   <= 1'b0;
                        if (start_bad) begin
                            invalid <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx   <= '0;
                            carry <= op;
                            busy  <= 1'b1;
                            state <= PASS1;
                        end
                    end
                end
                PASS1: begin
                    result[{idx, 2'b00} +: 4] <= sum_dig;
                    carry <= sum_c;
                    if (last) begin
                        if (!op_q || sum_c) begin
                            carry_out <= ~op_q & sum_c;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // no end carry on subtract means a<b: magnitude needs recomplementing
                            sign  <= 1'b1;
                            idx   <= '0;
                            carry <= 1'b1;
                            state <= PASS2;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                PASS2: begin
                    result[{idx, 2'b00} +: 4] <= comp_dig;
                    carry <= comp_c;
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Table-driven bench for bcd_serial_addsub (DIGITS=4) plus hand-written
// sequences for reset abort, start-while-busy and back-to-back operation.
module tb_bcd_serial_addsub;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carryOut;
    logic        sign;
    logic        invalid;

    int checks   = 0;
    int failures = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carryOut),
        .sign      (sign),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expResult;
        logic        expCarry;
        logic        expSign;
        logic        expInvalid;
        int          expDoneCycle;
        logic        chkMid;
        logic [15:0] expMid;
    } vec_t;

    vec_t vecs[11];

    int          doneCycle;
    int          busyCount;
    logic        pulseLow;
    logic [15:0] midResult;
    logic [15:0] gotResult;
    logic        gotCarry;
    logic        gotSign;
    logic        gotInvalid;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge: that negedge is cycle 0 with start high.
    task automatic applyStimulus(input logic o, input logic [15:0] av, input logic [15:0] bv);
        start     = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        doneCycle = -1;
        busyCount = 0;
        midResult = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                op    = ~o;
            end
            if (c == 5) midResult = result;
            if (busy) busyCount++;
            if (done) begin
                doneCycle = c;
                break;
            end
        end
        gotResult  = result;
        gotCarry   = carryOut;
        gotSign    = sign;
        gotInvalid = invalid;
        @(negedge clk);
        pulseLow = ~done;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 9, 1'b1, 16'h6234};
        vecs[6]  = '{1'b0, 16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 9, 1'b1, 16'h9999};
        vecs[9]  = '{1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 16'h0100, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0, 16'h0000};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_state", 32'({busy, done, result, carryOut, sign, invalid}), 32'h0);

        // Each call returns at the negedge after done, so vectors run back-to-back
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("v%0d_done_cycle", i), 32'(doneCycle), 32'(vecs[i].expDoneCycle));
            checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busyCount), 32'(vecs[i].expDoneCycle - 1));
            checkOutput($sformatf("v%0d_done_pulse", i), 32'(pulseLow), 32'h1);
            checkOutput($sformatf("v%0d_result", i), 32'(gotResult), 32'(vecs[i].expResult));
            checkOutput($sformatf("v%0d_carry_out", i), 32'(gotCarry), 32'(vecs[i].expCarry));
            checkOutput($sformatf("v%0d_sign", i), 32'(gotSign), 32'(vecs[i].expSign));
            checkOutput($sformatf("v%0d_invalid", i), 32'(gotInvalid), 32'(vecs[i].expInvalid));
            if (vecs[i].chkMid)
                checkOutput($sformatf("v%0d_pass1_result", i), 32'(midResult), 32'(vecs[i].expMid));
        end

        // Reset asserted during cycle 3 of a subtract aborts it with no done pulse
        begin
            int dones;
            start = 1'b1; op = 1'b1; a = 16'h1234; b = 16'h5000;
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            checkOutput("abort_outputs", 32'({busy, done, result, carryOut, sign, invalid}), 32'h0);
            dones = 0;
            repeat (15) begin
                @(negedge clk);
                if (done) dones++;
            end
            checkOutput("abort_no_done", 32'(dones), 32'h0);
        end

        // start pulsed while busy is ignored
        begin
            int dones;
            int firstDone;
            start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
            dones = 0;
            firstDone = -1;
            for (int c = 1; c <= 25; c++) begin
                @(negedge clk);
                start = (c == 2);
                if (c == 2) begin
                    op = 1'b1; a = 16'h0000; b = 16'h0001;
                end
                if (done) begin
                    dones++;
                    if (firstDone < 0) begin
                        firstDone = c;
                        gotResult = result;
                        gotSign   = sign;
                    end
                end
            end
            checkOutput("busy_start_done_cycle", 32'(firstDone), 32'd5);
            checkOutput("busy_start_result", 32'(gotResult), 32'h6912);
            checkOutput("busy_start_sign", 32'(gotSign), 32'h0);
            checkOutput("busy_start_one_done", 32'(dones), 32'h1);
            checkOutput("busy_start_result_held", 32'(result), 32'h6912);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
